cluster_apu_arbiter: RTL and testbench

//  Shares one APU/FPU instance between NumCores cluster cores when EnableSharedFpu=1
//  (one instance per shared FPU; NumSharedFpu instances total).

---
 rtl/cluster_apu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_cluster_apu_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_apu_arbiter.sv
// cluster_apu_arbiter: shares one APU/FPU between NumCores cores.
// Round-robin arbiter with winner lock, zero-latency grant, and an in-order
// ID FIFO that steers each result back to the core that issued the op.
// Optional build macro: CLUSTER_APU_ARB_PERF_EN adds grant/stall counters.
//
// state | meaning
// IDLE  | no winner locked; winner chosen round-robin from rr_ptr each cycle
// HOLD  | winner latched after an unanswered request; held until transfer or req drop
module cluster_apu_arbiter #(
    parameter int NumCores       = 8,
    parameter int MaxOutstanding = 4,
    parameter int NArgs          = 3,
    parameter int WOp            = 6,
    parameter int WType          = 3,
    parameter int NDsFlags       = 15,
    parameter int NUsFlags       = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumCores-1:0]           core_req_i,
    input  logic [NumCores*NArgs*32-1:0]  core_operands_i,
    input  logic [NumCores*WOp-1:0]       core_op_i,
    input  logic [NumCores*WType-1:0]     core_type_i,
    input  logic [NumCores*NDsFlags-1:0]  core_flags_i,
    output logic [NumCores-1:0]           core_gnt_o,
    output logic [NumCores-1:0]           core_rvalid_o,
    output logic [31:0]                   core_rdata_o,
    output logic [NUsFlags-1:0]           core_rflags_o,
    output logic                          apu_req_o,
    output logic [NArgs*32-1:0]           apu_operands_o,
    output logic [WOp-1:0]                apu_op_o,
    output logic [WType-1:0]              apu_type_o,
    output logic [NDsFlags-1:0]           apu_flags_o,
    input  logic                          apu_gnt_i,
    input  logic                          apu_rvalid_i,
    input  logic [31:0]                   apu_rdata_i,
    input  logic [NUsFlags-1:0]           apu_rflags_i,
    output logic                          err_o
`ifdef CLUSTER_APU_ARB_PERF_EN
    ,
    output logic [NumCores-1:0][31:0]     perf_grants_o,
    output logic [31:0]                   perf_stall_o
`endif
);

    localparam int IdxW  = $clog2(NumCores);
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding) + 1;
    localparam int OpndW = NArgs * 32;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, lock_q, lock_d, rr_idx, sel;
    logic            any_req, full, transfer, pop;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;

    // Pointers wrap at MaxOutstanding explicitly so depth 1 also works.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign any_req  = |core_req_i;
    assign full     = (count_q == CntW'(MaxOutstanding));
    assign transfer = apu_req_o & apu_gnt_i;
    assign pop      = apu_rvalid_i & (count_q != '0);
    assign err_o    = apu_rvalid_i & (count_q == '0);

    // Round-robin scan: first requester at or above rr_ptr, wrapping.
    always_comb begin
        int  j;
        logic found;
        rr_idx = rr_ptr_q;
        found  = 1'b0;
        j      = 0;
        for (int i = 0; i < NumCores; i++) begin
            j = (int'(rr_ptr_q) + i) % NumCores;
            if (!found && core_req_i[IdxW'(j)]) begin
                rr_idx = IdxW'(j);
                found  = 1'b1;
            end
        end
    end

    // Next-state and request: a full FIFO blocks requests even if it pops this cycle.
    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        sel       = rr_idx;
        apu_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                sel       = rr_idx;
                apu_req_o = any_req & ~full;
                if (any_req && !(apu_req_o && apu_gnt_i)) begin
                    state_d = HOLD;
                    lock_d  = rr_idx;
                end
            end
            HOLD: begin
                sel       = lock_q;
                apu_req_o = core_req_i[lock_q] & ~full;
                if (!core_req_i[lock_q] || (apu_gnt_i && !full)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign apu_operands_o = core_operands_i[int'(sel)*OpndW +: OpndW];
    assign apu_op_o       = core_op_i[int'(sel)*WOp +: WOp];
    assign apu_type_o     = core_type_i[int'(sel)*WType +: WType];
    assign apu_flags_o    = core_flags_i[int'(sel)*NDsFlags +: NDsFlags];
    assign core_rdata_o   = apu_rdata_i;
    assign core_rflags_o  = apu_rflags_i;

    // One-hot grant to the winner and one-hot rvalid to the FIFO head owner.
    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        if (transfer) core_gnt_o[sel] = 1'b1;
        if (pop)      core_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
    end

    // FSM state, winner lock and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            lock_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            if (transfer) begin
                rr_ptr_q <= (sel == IdxW'(NumCores - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    // ID FIFO storage; contents are only meaningful below count_q.
    always_ff @(posedge clk_i) begin
        if (transfer) fifo_q[wr_ptr_q] <= sel;
    end

    // ID FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (transfer) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({transfer, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CLUSTER_APU_ARB_PERF_EN
    // Saturating per-core grant counters and shared stall counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_grants_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            for (int c = 0; c < NumCores; c++) begin
                if (transfer && (sel == IdxW'(c)) && (perf_grants_o[c] != '1)) begin
                    perf_grants_o[c] <= perf_grants_o[c] + 32'd1;
                end
            end
            if (any_req && !transfer && (perf_stall_o != '1)) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cluster_apu_arbiter.sv
// Bench for cluster_apu_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of arbitration and routing.
module tb_cluster_apu_arbiter;

    localparam int NC = 8, MO = 4, NARGS = 3, WOP = 6, WTYPE = 3, NDS = 15, NUS = 5;

    logic                  clk_i = 1'b0, rst_ni = 1'b0;
    logic [NC-1:0]         core_req_i = '0;
    logic [NC*NARGS*32-1:0] op_bus;
    logic [NC*WOP-1:0]     opc_bus;
    logic [NC*WTYPE-1:0]   typ_bus;
    logic [NC*NDS-1:0]     flg_bus;
    logic [NC-1:0]         core_gnt_o, core_rvalid_o;
    logic [31:0]           core_rdata_o;
    logic [NUS-1:0]        core_rflags_o;
    logic                  apu_req_o;
    logic [NARGS*32-1:0]   apu_operands_o;
    logic [WOP-1:0]        apu_op_o;
    logic [WTYPE-1:0]      apu_type_o;
    logic [NDS-1:0]        apu_flags_o;
    logic                  apu_gnt_i = 1'b0, apu_rvalid_i = 1'b0;
    logic [31:0]           apu_rdata_i = '0;
    logic [NUS-1:0]        apu_rflags_i = '0;
    logic                  err_o;
`ifdef CLUSTER_APU_ARB_PERF_EN
    logic [NC-1:0][31:0]   perf_grants_o;
    logic [31:0]           perf_stall_o;
`endif

    cluster_apu_arbiter #(
        .NumCores(NC), .MaxOutstanding(MO), .NArgs(NARGS), .WOp(WOP),
        .WType(WTYPE), .NDsFlags(NDS), .NUsFlags(NUS)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_operands_i(op_bus), .core_op_i(opc_bus),
        .core_type_i(typ_bus), .core_flags_i(flg_bus),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
        .apu_req_o(apu_req_o), .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o),
        .apu_type_o(apu_type_o), .apu_flags_o(apu_flags_o),
        .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i),
        .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
        .err_o(err_o)
`ifdef CLUSTER_APU_ARB_PERF_EN
        , .perf_grants_o(perf_grants_o), .perf_stall_o(perf_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;

    // Reference model: next round-robin start, locked winner (-1 none), outstanding IDs in order.
    int m_rr = 0;
    int m_lock = -1;
    int m_q[$];

    logic [NC-1:0] last_gnt, last_rv;
    logic          last_req, last_err;
    int            g_core;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_fields(input int c);
        op_bus[c*NARGS*32 +: NARGS*32] = {$urandom(), $urandom(), $urandom()};
        opc_bus[c*WOP +: WOP]          = WOP'($urandom());
        typ_bus[c*WTYPE +: WTYPE]      = WTYPE'($urandom());
        flg_bus[c*NDS +: NDS]          = NDS'($urandom());
    endtask

    task automatic model_clear();
        m_rr = 0;
        m_lock = -1;
        m_q.delete();
    endtask

    // One cycle: drive at negedge, compare at negedge+1, advance model at posedge.
    task automatic step(input logic [NC-1:0] req, input logic gnt, input logic rv,
                        input logic [31:0] rdata);
        logic [NC-1:0] exp_gnt, exp_rv;
        logic exp_req, exp_err;
        int win;
        @(negedge clk_i);
        core_req_i   = req;
        apu_gnt_i    = gnt;
        apu_rvalid_i = rv;
        apu_rdata_i  = rdata;
        apu_rflags_i = NUS'($urandom());
        #1;
        win = -1;
        if (m_lock >= 0) win = m_lock;
        else for (int k = 0; k < NC; k++) if (win < 0 && req[(m_rr + k) % NC]) win = (m_rr + k) % NC;
        exp_req = (win >= 0) && req[win] && (m_q.size() < MO);
        exp_gnt = (exp_req && gnt) ? (NC'(1) << win) : '0;
        exp_rv  = '0;
        exp_err = 1'b0;
        if (rv) begin
            if (m_q.size() > 0) exp_rv = NC'(1) << m_q[0];
            else exp_err = 1'b1;
        end
        check_eq("apu_req", 128'(apu_req_o), 128'(exp_req));
        check_eq("core_gnt", 128'(core_gnt_o), 128'(exp_gnt));
        check_eq("core_rvalid", 128'(core_rvalid_o), 128'(exp_rv));
        check_eq("err", 128'(err_o), 128'(exp_err));
        if (exp_req) begin
            check_eq("operands", 128'(apu_operands_o), 128'(op_bus[win*NARGS*32 +: NARGS*32]));
            check_eq("op", 128'(apu_op_o), 128'(opc_bus[win*WOP +: WOP]));
            check_eq("type", 128'(apu_type_o), 128'(typ_bus[win*WTYPE +: WTYPE]));
            check_eq("flags", 128'(apu_flags_o), 128'(flg_bus[win*NDS +: NDS]));
        end
        if (rv) begin
            check_eq("rdata", 128'(core_rdata_o), 128'(rdata));
            check_eq("rflags", 128'(core_rflags_o), 128'(apu_rflags_i));
        end
        last_gnt = core_gnt_o;
        last_rv  = core_rvalid_o;
        last_req = apu_req_o;
        last_err = err_o;
        g_core   = (exp_req && gnt) ? win : -1;
        @(posedge clk_i);
        if (rv && m_q.size() > 0) void'(m_q.pop_front());
        if (g_core >= 0) begin
            m_q.push_back(g_core);
            m_rr = (g_core + 1) % NC;
            m_lock = -1;
            new_fields(g_core);
        end else if (m_lock >= 0) begin
            if (!req[m_lock]) m_lock = -1;
        end else if (req != '0) begin
            m_lock = win;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"}, 128'(apu_req_o), 128'(0));
        check_eq({tag, "_gnt"}, 128'(core_gnt_o), 128'(0));
        check_eq({tag, "_rv"}, 128'(core_rvalid_o), 128'(0));
        check_eq({tag, "_err"}, 128'(err_o), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        core_req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_quiet("rst");
        model_clear();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [NC-1:0] pend;
        int seq[3] = '{0, 3, 5};
        for (int c = 0; c < NC; c++) new_fields(c);

        do_reset();

        // Continuous requesters 0,3,5 with a result returning each cycle.
        for (int i = 0; i < 7; i++) begin
            step(8'b0010_1001, 1'b1, i > 0, $urandom());
            check_eq("rr_seq", 128'(last_gnt), 128'(NC'(1) << seq[i % 3]));
        end
        step('0, 1'b0, 1'b1, $urandom());

        // Winner lock: core 2 held while core 1 joins.
        do_reset();
        step(8'h04, 1'b0, 1'b0, '0);
        step(8'h06, 1'b0, 1'b0, '0);
        step(8'h06, 1'b0, 1'b0, '0);
        step(8'h06, 1'b1, 1'b0, '0);
        check_eq("lock_first", 128'(last_gnt), 128'(8'h04));
        step(8'h02, 1'b1, 1'b0, '0);
        check_eq("lock_second", 128'(last_gnt), 128'(8'h02));
        step('0, 1'b0, 1'b1, $urandom());
        check_eq("lock_rv0", 128'(last_rv), 128'(8'h04));
        step('0, 1'b0, 1'b1, $urandom());
        check_eq("lock_rv1", 128'(last_rv), 128'(8'h02));

        // Full FIFO blocks, including the cycle a pop happens.
        do_reset();
        repeat (MO) step(8'hFF, 1'b1, 1'b0, '0);
        step(8'hFF, 1'b1, 1'b0, '0);
        check_eq("full_req", 128'(last_req), 128'(0));
        check_eq("full_gnt", 128'(last_gnt), 128'(0));
        step(8'hFF, 1'b1, 1'b1, $urandom());
        check_eq("full_pop_gnt", 128'(last_gnt), 128'(0));
        step(8'hFF, 1'b1, 1'b0, '0);
        check_eq("after_pop_req", 128'(last_req), 128'(1));
        repeat (MO) step('0, 1'b0, 1'b1, $urandom());

        // Result routing: 6 then 1.
        do_reset();
        step(8'h40, 1'b1, 1'b0, '0);
        step(8'h02, 1'b1, 1'b0, '0);
        step('0, 1'b0, 1'b1, 32'hAAAA);
        check_eq("route6", 128'(last_rv), 128'(8'h40));
        step('0, 1'b0, 1'b1, 32'h5555);
        check_eq("route1", 128'(last_rv), 128'(8'h02));

        // Result with nothing outstanding.
        step('0, 1'b0, 1'b1, $urandom());
        check_eq("empty_err", 128'(last_err), 128'(1));
        check_eq("empty_rv", 128'(last_rv), 128'(0));
        step('0, 1'b0, 1'b0, '0);
        check_eq("err_pulse", 128'(last_err), 128'(0));

        // Reset with three ops in flight.
        do_reset();
        step(8'h04, 1'b1, 1'b0, '0);
        step(8'h08, 1'b1, 1'b0, '0);
        step(8'h10, 1'b1, 1'b0, '0);
        #2;
        core_req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_quiet("midrst");
        model_clear();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step('0, 1'b0, 1'b1, $urandom());
        check_eq("midrst_empty", 128'(last_err), 128'(1));
        step(8'h42, 1'b1, 1'b0, '0);
        check_eq("midrst_rr0", 128'(last_gnt), 128'(8'h02));
        repeat (2) step('0, 1'b0, 1'b1, $urandom());

        // Random traffic: requests stay up until granted.
        pend = '0;
        for (int i = 0; i < 400; i++) begin
            pend |= NC'($urandom()) & NC'($urandom());
            step(pend, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom());
            if (g_core >= 0) pend[g_core] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
